// File: rtl/width_adapter_arbiter.sv
// Round-robin arbiter that lets NUM_REQ narrow requesters take turns feeding
// whole SIZE_OUT words (BEATS narrow beats each) into a width adapter. The
// grant is locked for a full word and is handed over without an idle cycle.
module width_adapter_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SIZE_IN  = 8,
    parameter int SIZE_OUT = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*SIZE_IN-1:0]    req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          adp_valid,
    output logic [SIZE_IN-1:0]            adp_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          word_done,
    output logic [$clog2(NUM_REQ)-1:0]    word_owner
);

    localparam int BEATS = SIZE_OUT / SIZE_IN;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (((SIZE_OUT % SIZE_IN) != 0) || (NUM_REQ < 2)) begin : g_bad_params
            $error("width_adapter_arbiter: SIZE_OUT must be a multiple of SIZE_IN and NUM_REQ >= 2");
        end
    endgenerate

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    r_last_grant;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_word_done;
    logic [ID_W-1:0]    r_word_owner;

    logic               w_handshake;
    logic               w_last_beat;
    logic [ID_W-1:0]    w_arb_base;
    logic [NUM_REQ-1:0] w_arb_mask;
    logic               w_arb_found;
    logic [ID_W-1:0]    w_arb_pick;

    // Requester index `off` positions after `base`, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    assign w_handshake = (r_state == S_BURST) && req_valid[r_grant_id];
    assign w_last_beat = w_handshake && (r_beat_cnt == CNT_W'(BEATS - 1));

    // Round-robin search: from last_grant+1 when idle, from grant_id+1 (grantee excluded) on a last beat.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front so no path can infer a latch.
        w_arb_base  = (r_state == S_IDLE) ? r_last_grant : r_grant_id;
        w_arb_mask  = req_valid;
        w_arb_found = 1'b0;
        w_arb_pick  = '0;
        if (r_state == S_BURST) begin
            w_arb_mask[r_grant_id] = 1'b0;
        end
        // Walk from the farthest offset down so the nearest requester is assigned last and wins.
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (w_arb_mask[rr_index(w_arb_base, off)]) begin
                w_arb_found = 1'b1;
                w_arb_pick  = rr_index(w_arb_base, off);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: leave IDLE on any request, return only when a word ends with nobody waiting.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_found) w_next_state = S_BURST;
            S_BURST: if (w_last_beat && !w_arb_found) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: one-hot ready to the grantee and a zero-when-idle beat passthrough.
    always_comb begin
        req_ready = '0;
        adp_valid = 1'b0;
        adp_data  = '0;
        busy      = (r_state == S_BURST);
        if (r_state == S_BURST) begin
            req_ready[r_grant_id] = 1'b1;
        end
        if (w_handshake) begin
            adp_valid = 1'b1;
            adp_data  = req_data[int'(r_grant_id) * SIZE_IN +: SIZE_IN];
        end
    end

    // Grant, beat counter and word-complete pulse bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_word_done  <= 1'b0;
            r_word_owner <= '0;
        end else begin
            r_word_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_found) begin
                        r_grant_id <= w_arb_pick;
                        r_beat_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (w_last_beat) begin
                        r_last_grant <= r_grant_id;
                        r_beat_cnt   <= '0;
                        r_word_done  <= 1'b1;
                        r_word_owner <= r_grant_id;
                        if (w_arb_found) begin
                            r_grant_id <= w_arb_pick;
                        end
                    end else if (w_handshake) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign grant_id   = r_grant_id;
    assign word_done  = r_word_done;
    assign word_owner = r_word_owner;

endmodule
